cpu_control: RTL
================

Name: cpu_control

Overview:
Multi-cycle control unit and instruction sequencer for the CPU core. It fetches instructions, decodes an RV32I subset, and drives the ALU controls (ALOUP, J, B) and the operand-select signals. It consumes the ALU's registered RES and EQUAL outputs to produce register-file write-back and the next PC. It sits between instruction memory, the register file and the ALU, as the initiating end of the ALU control interface.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, datapath width. Only 32 is supported.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RST  in  1  synchronous, active-high reset, sampled on the rising edge of CLK.
IREQ  out  1  instruction fetch request.
IADDR  out  32  fetch address; equals PC.
IVALID  in  1  IDATA valid; completes the fetch.
IDATA  in  32  instruction word.
RS1  out  5  register-file read address 1 = IR[19:15].
RS2  out  5  register-file read address 2 = IR[24:20].
RD  out  5  write-back address = IR[11:7].
REGWE  out  1  register-file write enable; one-cycle pulse.
REGWDATA  out  32  write-back data.
ALOUP  out  3  ALU operation select.
J  out  1  ALU subtract select.
B  out  1  ALU branch-compare enable.
ALUSRC  out  1  ALU X2 source select: 0 = rs2, 1 = IMM.
IMM  out  32  sign-extended immediate.
RES  in  32  ALU result; registered by the ALU, valid one cycle after the controls.
EQUAL  in  1  ALU equality flag.
PC  out  32  current program counter.
ILLEGAL  out  1  sticky illegal-instruction flag.

Behaviour:
- States: FETCH, DECODE, EXEC, WB, TRAP.
- Reset values: state=FETCH, PC=RESET_PC, IR=0, ILLEGAL=0. All other outputs reset to 0: IREQ, REGWE, ALOUP, J, B, ALUSRC, IMM, REGWDATA.
- RST overrides every state, including a fetch in progress and TRAP. An IVALID arriving in the same cycle as RST is ignored.
- FETCH: IREQ=1, IADDR=PC. Both are held stable until IVALID=1. On IVALID, IR<=IDATA, IREQ drops next cycle, go to DECODE.
- DECODE (1 cycle):
  - RS1, RS2 and IMM are driven from IR.
  - Immediate formats: I, B, J and U, all sign-extended to 32 bits.
  - Supported opcodes: OP 0110011, OP-IMM 0010011, BRANCH 1100011 (funct3 000 BEQ, 001 BNE only), JAL 1101111, LUI 0110111.
  - Any other opcode or branch funct3 sets ILLEGAL=1 and goes to TRAP.
- EXEC (1 cycle): ALU controls are valid in this cycle.
  - OP: ALOUP=funct3, J=IR[30] only when funct3=000, else J=0, ALUSRC=0.
  - OP-IMM: ALOUP=funct3, J=0, ALUSRC=1.
  - BRANCH: ALOUP=000, J=1, B=1, ALUSRC=0.
  - JAL and LUI: ALU controls are don't-care and are driven to 0.
  - B is 1 only in EXEC for branches; it is 0 in every other state.
- WB (1 cycle): RES and EQUAL are sampled here.
  - OP and OP-IMM: REGWE=1, REGWDATA=RES.
  - LUI: REGWE=1, REGWDATA=IMM.
  - JAL: REGWE=1, REGWDATA=PC+4, PC<=PC+IMM.
  - BEQ: PC<=PC+IMM if EQUAL=1, else PC+4. BNE uses the inverse condition. REGWE=0 for branches.
  - All non-jump, non-taken cases: PC<=PC+4.
  - REGWE is suppressed when RD=0.
  - Return to FETCH.
- TRAP: all enables are 0, PC is frozen, ILLEGAL=1. Only RST exits TRAP.
- Timing: 4 cycles per instruction with zero-wait IVALID (IVALID in the first FETCH cycle). Each extra fetch wait cycle adds one.
- Arithmetic: PC adds are modulo 2^32 and wrap silently, so 0xFFFF_FFFC+4 = 0. Misaligned targets are not checked.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_LUI;
  - ALOUP codes ALU_ADD 000 through ALU_AND 111;
  - state encoding localparams;
  - WB-select codes WB_RES, WB_IMM, WB_PC4.
- One natural sub-module: imm_gen, a combinational IR-to-IMM immediate generator covering the I, B, J and U formats.
- The FSM, PC register and write-back mux stay in cpu_control.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), IVALID in the first FETCH cycle, RES=0x0000_0007 in WB:
  - EXEC: ALOUP=000, J=0, ALUSRC=0.
  - WB: REGWE=1, RD=3, REGWDATA=7, PC 0 to 4.
  - Total 4 cycles.
- SUB x3,x1,x2 (0x402081B3) -> J=1 in EXEC. ADDI x1,x0,5 (0x00500093) -> ALUSRC=1, IMM=5, ALOUP=000, J=0.
- BEQ x1,x2,+8 (0x00208463) at PC=0x10:
  - EQUAL=1 -> B=1 and J=1 in EXEC, next PC=0x18, REGWE=0.
  - Repeat with EQUAL=0 -> next PC=0x14.
- JAL x1,-4 (0xFFDFF0EF) at PC=0x20 -> REGWE=1, RD=1, REGWDATA=0x24, next PC=0x1C. LUI x5,0x12345 (0x123452B7) -> REGWDATA=0x1234_5000.
- IDATA=0xFFFF_FFFF -> ILLEGAL=1 after DECODE, IREQ stays 0 for ≥10 cycles, PC is unchanged. RST=1 -> ILLEGAL=0, PC=RESET_PC, IREQ=1 on the next cycle.
- IVALID withheld 3 cycles -> IREQ and IADDR held stable throughout. RST asserted during the wait, with IVALID=1 in the same cycle -> IR is not loaded, state=FETCH, PC=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_control sequencer: opcodes, ALU operation
// codes, sequencer states and write-back source selects.
package cpu_pkg;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_LUI    = 7'b0110111
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [1:0] {
    WB_RES,
    WB_IMM,
    WB_PC4,
    WB_NONE
  } wb_sel_t;

endpackage

// File: rtl/cpu_control_imm_gen.sv
// Combinational immediate generator: selects the I, B, J or U format from
// the opcode and sign-extends it to 32 bits.
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (ir[6:0])
      OPC_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OPC_LUI:    imm = {ir[31:12], 12'b0};
      default:    imm = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for an RV32I subset; drives the
// ALU controls and produces register write-back and the next PC.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            IREQ,
  output logic [XLEN-1:0] IADDR,
  input  logic            IVALID,
  input  logic [XLEN-1:0] IDATA,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2,
  output logic [4:0]      RD,
  output logic            REGWE,
  output logic [XLEN-1:0] REGWDATA,
  output logic [2:0]      ALOUP,
  output logic            J,
  output logic            B,
  output logic            ALUSRC,
  output logic [XLEN-1:0] IMM,
  input  logic [XLEN-1:0] RES,
  input  logic            EQUAL,
  output logic [XLEN-1:0] PC,
  output logic            ILLEGAL
);

  state_t          state, state_nx;
  logic [XLEN-1:0] pc_q, pc_nx, ir, imm;
  logic [XLEN-1:0] pc_plus4, pc_target;
  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic            illegal_q, legal, take, wr_rd;
  wb_sel_t         wb_sel;

  imm_gen u_imm_gen (
    .ir  (ir),
    .imm (imm)
  );

  assign opc       = ir[6:0];
  assign funct3    = ir[14:12];
  assign pc_plus4  = pc_q + XLEN'(4);
  assign pc_target = pc_q + imm;
  assign wr_rd     = |ir[11:7];
  // BNE is funct3=001, so funct3[0] inverts the equality sense.
  assign take      = (opc == OPC_BRANCH) && (EQUAL ^ funct3[0]);

  assign IADDR   = pc_q;
  assign PC      = pc_q;
  assign RS1     = ir[19:15];
  assign RS2     = ir[24:20];
  assign RD      = ir[11:7];
  assign IMM     = imm;
  assign ILLEGAL = illegal_q;

  always_comb begin
    legal  = 1'b0;
    wb_sel = WB_NONE;
    case (opc)
      OPC_OP, OPC_OPIMM: begin legal = 1'b1; wb_sel = WB_RES; end
      OPC_LUI:           begin legal = 1'b1; wb_sel = WB_IMM; end
      OPC_JAL:           begin legal = 1'b1; wb_sel = WB_PC4; end
      OPC_BRANCH:        legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      default:           ;
    endcase
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    IREQ     = 1'b0;
    REGWE    = 1'b0;
    REGWDATA = '0;
    ALOUP    = '0;
    J        = 1'b0;
    B        = 1'b0;
    ALUSRC   = 1'b0;
    case (state)
      ST_FETCH: begin
        IREQ = 1'b1;
        if (IVALID) state_nx = ST_DECODE;
      end
      ST_DECODE: state_nx = legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        state_nx = ST_WB;
        case (opc)
          OPC_OP: begin
            ALOUP = funct3;
            J     = (funct3 == ALU_ADD) && ir[30];
          end
          OPC_OPIMM: begin
            ALOUP  = funct3;
            ALUSRC = 1'b1;
          end
          OPC_BRANCH: begin
            ALOUP = ALU_ADD;
            J     = 1'b1;
            B     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_WB: begin
        state_nx = ST_FETCH;
        pc_nx    = pc_plus4;
        case (wb_sel)
          WB_RES: begin REGWE = wr_rd; REGWDATA = RES; end
          WB_IMM: begin REGWE = wr_rd; REGWDATA = imm; end
          WB_PC4: begin REGWE = wr_rd; REGWDATA = pc_plus4; pc_nx = pc_target; end
          default: if (take) pc_nx = pc_target;
        endcase
      end
      default: ;
    endcase
    // Outputs read as zero while reset is held, whatever state is registered.
    if (RST) begin
      IREQ     = 1'b0;
      REGWE    = 1'b0;
      REGWDATA = '0;
      ALOUP    = '0;
      J        = 1'b0;
      B        = 1'b0;
      ALUSRC   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      if (state == ST_FETCH && IVALID) ir <= IDATA;
      if (state == ST_DECODE && !legal) illegal_q <= 1'b1;
    end
  end

endmodule
